// File: rtl/aes_pkg.sv
// Shared AES-128 types and the key-schedule round-constant lookup.
// Blocks are packed with byte 0 in the least significant bits.
package aes_pkg;

    typedef logic [7:0]   byte_t;
    typedef byte_t [15:0] block_t;

    localparam int unsigned NUM_RCON = 10;

    // Indices 10..15 give 00, so an out-of-range round index leaves byte 0 of t untouched.
    function automatic byte_t rcon_lookup(input logic [3:0] idx);
        byte_t r;
        case (idx)
            4'd0:    r = 8'h01;
            4'd1:    r = 8'h02;
            4'd2:    r = 8'h04;
            4'd3:    r = 8'h08;
            4'd4:    r = 8'h10;
            4'd5:    r = 8'h20;
            4'd6:    r = 8'h40;
            4'd7:    r = 8'h80;
            4'd8:    r = 8'h1b;
            4'd9:    r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in and one byte out.
module aes_sbox
    import aes_pkg::*;
(
    input  byte_t a,
    output byte_t s
);
    always_comb begin
        s = 8'h00;
        case (a)
            8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
            8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
            8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
            8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
            8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
            8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
            8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
            8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
            8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
            8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
            8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
            8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
            8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
            8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
            8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
            8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
            8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
            8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
            8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
            8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
            8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
            8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
            8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
            8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
            8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
            8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
            8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
            8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
            8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
            8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
            8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
            8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
            default: s = 8'h00;
        endcase
    end
endmodule

// File: rtl/key_expand.sv
// One AES-128 key-schedule step with a registered output stage.
// Words are column-major: bytes 0..3 form w0 (byte 0 most significant), and so on.
module key_expand
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [127:0] key,
    input  logic [3:0]   rc,
    output logic [127:0] keyout,
    output logic         out_valid
);
    block_t kin;
    block_t knext;
    byte_t  sub0, sub1, sub2, sub3;
    byte_t  t [4];

    assign kin = key;

    // RotWord on w3 is folded into which byte each S-box sees.
    aes_sbox u_sbox0 (.a(kin[13]), .s(sub0));
    aes_sbox u_sbox1 (.a(kin[14]), .s(sub1));
    aes_sbox u_sbox2 (.a(kin[15]), .s(sub2));
    aes_sbox u_sbox3 (.a(kin[12]), .s(sub3));

    always_comb begin
        t[0]  = sub0 ^ rcon_lookup(rc);
        t[1]  = sub1;
        t[2]  = sub2;
        t[3]  = sub3;
        knext = '0;
        for (int k = 0; k < 4; k++) begin
            knext[k]      = kin[k]      ^ t[k];
            knext[4 + k]  = kin[4 + k]  ^ knext[k];
            knext[8 + k]  = kin[8 + k]  ^ knext[4 + k];
            knext[12 + k] = kin[12 + k] ^ knext[8 + k];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            keyout    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                keyout <= knext;
            end
        end
    end

endmodule

// File: tb/tb_key_expand.sv
// Self-checking bench for key_expand: FIPS-197 vectors, chained rounds, reset and hold
// corners, and random traffic against a word-level key-schedule model.
module tb_key_expand;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [127:0] key;
    logic [3:0]   rc;
    logic [127:0] keyout;
    logic         out_valid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sb_tab [256];

    key_expand dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .key       (key),
        .rc        (rc),
        .keyout    (keyout),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] k;
        logic [3:0]   r;
        logic [127:0] e;
    } vec_t;

    vec_t vt [9];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from its definition: GF(2^8) inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox_def(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon_ref(input logic [3:0] r);
        logic [7:0] v = 8'h01;
        if (r >= 4'd10) return 8'h00;
        for (int i = 0; i < int'(r); i++) v = xt(v);
        return v;
    endfunction

    // Model works in FIPS-197 notation: the 128-bit value reads as w0 w1 w2 w3, MSB first.
    function automatic logic [127:0] model_next(input logic [127:0] f, input logic [3:0] r);
        logic [31:0] w [4];
        logic [31:0] rw, t;
        for (int j = 0; j < 4; j++) w[j] = f[127 - 32*j -: 32];
        rw = {w[3][23:0], w[3][31:24]};
        t  = {sb_tab[rw[31:24]], sb_tab[rw[23:16]], sb_tab[rw[15:8]], sb_tab[rw[7:0]]};
        t  = t ^ {rcon_ref(r), 24'h0};
        w[0] = w[0] ^ t;
        w[1] = w[1] ^ w[0];
        w[2] = w[2] ^ w[1];
        w[3] = w[3] ^ w[2];
        return {w[0], w[1], w[2], w[3]};
    endfunction

    // FIPS byte string to the port packing, where byte i lives at bits [8i+7:8i].
    function automatic logic [127:0] to_bus(input logic [127:0] f);
        logic [127:0] b;
        for (int i = 0; i < 16; i++) b[8*i +: 8] = f[127 - 8*i -: 8];
        return b;
    endfunction

    task automatic chk128(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] cur, expk;
        logic         v;

        for (int i = 0; i < 256; i++) sb_tab[i] = sbox_def(8'(i));

        vt[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd0, 128'ha0fafe1788542cb123a339392a6c7605};
        vt[1] = '{128'ha0fafe1788542cb123a339392a6c7605, 4'd1, 128'hf2c295f27a96b9435935807a7359f67f};
        vt[2] = '{128'h0,                                4'd0, 128'h62636363626363636263636362636363};
        vt[3] = '{128'h62636363626363636263636362636363, 4'd1, 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa};
        vt[4] = '{128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa, 4'd2, 128'h90973450696ccffaf2f457330b0fac99};
        vt[5] = '{128'h6920e299a5202a6d656e636869746f2a, 4'd0, 128'hfa8807605fa82d0d3ac64e6553b2214f};
        vt[6] = '{128'hfa8807605fa82d0d3ac64e6553b2214f, 4'd1, 128'hcf75838d90ddae80aa1be0e5f9a9c1aa};
        vt[7] = '{128'h0,                                4'd10, 128'h63636363636363636363636363636363};
        vt[8] = '{128'h0,                                4'd15, 128'h63636363636363636363636363636363};

        reset = 1'b1; in_valid = 1'b0; key = '0; rc = '0;
        #2;
        chk128("reset_keyout", keyout, 128'h0);
        chk1("reset_valid", out_valid, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Known-answer table, one vector per cycle.
        for (int i = 0; i < 9; i++) begin
            key = to_bus(vt[i].k); rc = vt[i].r; in_valid = 1'b1;
            tick();
            chk128($sformatf("kat%0d_keyout", i), keyout, to_bus(vt[i].e));
            chk1($sformatf("kat%0d_valid", i), out_valid, 1'b1);
            chk128($sformatf("kat%0d_model", i), model_next(vt[i].k, vt[i].r), vt[i].e);
        end

        // Full back-to-back schedule from the FIPS-197 cipher key.
        cur = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        for (int r = 0; r < 10; r++) begin
            key = to_bus(cur); rc = 4'(r); in_valid = 1'b1;
            tick();
            cur = model_next(cur, 4'(r));
            chk128($sformatf("chain_r%0d", r), keyout, to_bus(cur));
            chk1($sformatf("chain_valid_r%0d", r), out_valid, 1'b1);
        end
        chk128("chain_final", keyout, to_bus(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));

        // Idle cycle: a new key with in_valid low must not be captured.
        key = {$urandom, $urandom, $urandom, $urandom}; rc = 4'd3; in_valid = 1'b0;
        tick();
        chk128("hold_keyout", keyout, to_bus(cur));
        chk1("hold_valid", out_valid, 1'b0);

        // Random traffic with in_valid toggling.
        expk = to_bus(cur);
        for (int n = 0; n < 60; n++) begin
            cur = {$urandom, $urandom, $urandom, $urandom};
            v   = 1'($urandom_range(0, 1));
            key = to_bus(cur); rc = 4'($urandom_range(0, 15)); in_valid = v;
            if (v) expk = to_bus(model_next(cur, rc));
            tick();
            chk128($sformatf("rand%0d_keyout", n), keyout, expk);
            chk1($sformatf("rand%0d_valid", n), out_valid, v);
        end

        // Asynchronous reset between edges while a result is being presented.
        key = to_bus(vt[5].k); rc = 4'd0; in_valid = 1'b1;
        tick();
        chk1("pre_reset_valid", out_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk128("async_reset_keyout", keyout, 128'h0);
        chk1("async_reset_valid", out_valid, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) tick();
        chk128("post_reset_keyout", keyout, 128'h0);
        chk1("post_reset_valid", out_valid, 1'b0);

        key = to_bus(vt[0].k); rc = 4'd0; in_valid = 1'b1;
        tick();
        chk128("first_capture_keyout", keyout, to_bus(vt[0].e));
        chk1("first_capture_valid", out_valid, 1'b1);
        in_valid = 1'b0;
        tick();
        chk1("drop_valid", out_valid, 1'b0);
        chk128("drop_keyout", keyout, to_bus(vt[0].e));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
